cfg_dprio_shadow_status_initiator: RTL and testbench



---
 rtl/cfg_dprio_hs_pkg.sv | 18 +
 rtl/cfg_dprio_shadow_status_initiator_if.sv | 24 ++
 rtl/cfg_dprio_bitsync_srst.sv | 23 ++
 rtl/cfg_dprio_shadow_status_initiator.sv | 101 ++++++++++
 tb/tb_cfg_dprio_shadow_status_initiator.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_dprio_hs_pkg.sv
// Shared definitions for the DPRIO shadow-status handshake (initiator and shadow side).
package cfg_dprio_hs_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_CAPTURE = 3'd4
    } hs_state_t;

    function automatic int tmo_cnt_width(input int tmo_cycles);
        return $clog2(tmo_cycles + 1);
    endfunction

endpackage

// File: rtl/cfg_dprio_shadow_status_initiator_if.sv
// Handshake and status bus between the DPRIO initiator and its surroundings.
interface cfg_dprio_shadow_status_initiator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  err_clr;
    logic                  write_en;
    logic                  write_en_ack;
    logic [DATA_WIDTH-1:0] stat_data_in;
    logic [DATA_WIDTH-1:0] stat_data;
    logic                  stat_valid;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        input  req, err_clr, write_en_ack, stat_data_in,
        output write_en, stat_data, stat_valid, busy, timeout_err
    );

    modport slave (
        output req, err_clr, write_en_ack, stat_data_in,
        input  write_en, stat_data, stat_valid, busy, timeout_err
    );
endinterface

// File: rtl/cfg_dprio_bitsync_srst.sv
// Multi-flop single-bit synchronizer, synchronous active-high reset to 0.
module cfg_dprio_bitsync_srst
    import cfg_dprio_hs_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/cfg_dprio_shadow_status_initiator.sv
// DPRIO-side master of the 4-phase shadow-status handshake with per-phase timeout.
//   state   | meaning
//   IDLE    | waiting for req
//   DRAIN   | stale ack from an aborted handshake, wait for it to fall
//   ASSERT  | write_en high, wait for ack
//   RELEASE | write_en low, wait for ack to fall
//   CAPTURE | status bus frozen, sample it and pulse stat_valid
module cfg_dprio_shadow_status_initiator
    import cfg_dprio_hs_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic                                clk,
    input logic                                rst,
    cfg_dprio_shadow_status_initiator_if.master hs
);
    localparam int             CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hs_state_t             r_state;
    hs_state_t             w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_cnt_last;
    logic                  w_cnt_run;
    logic                  w_tmo;
    logic                  w_ack_s;
    logic                  r_write_en;
    logic                  r_stat_valid;
    logic                  r_busy;
    logic                  r_timeout_err;
    logic [DATA_WIDTH-1:0] r_stat_data;

    cfg_dprio_bitsync_srst #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .i_d (hs.write_en_ack),
        .o_q (w_ack_s)
    );

    assign w_cnt_last = (r_cnt == TMO_LAST);
    assign w_cnt_run  = (r_state == ST_DRAIN) || (r_state == ST_ASSERT) ||
                        (r_state == ST_RELEASE);

    // Ack progress wins over a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (hs.req) w_state_nxt = w_ack_s ? ST_DRAIN : ST_ASSERT;
            end
            ST_DRAIN: begin
                if (!w_ack_s)       w_state_nxt = ST_ASSERT;
                else if (w_cnt_last) w_tmo      = 1'b1;
            end
            ST_ASSERT: begin
                if (w_ack_s)        w_state_nxt = ST_RELEASE;
                else if (w_cnt_last) w_tmo      = 1'b1;
            end
            ST_RELEASE: begin
                if (!w_ack_s)       w_state_nxt = ST_CAPTURE;
                else if (w_cnt_last) w_tmo      = 1'b1;
            end
            ST_CAPTURE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (w_tmo) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_write_en    <= 1'b0;
            r_stat_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stat_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= ((w_state_nxt != r_state) || !w_cnt_run) ? '0 : r_cnt + CNT_W'(1);
            r_write_en   <= (w_state_nxt == ST_ASSERT);
            r_stat_valid <= (w_state_nxt == ST_CAPTURE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            // ack_s already low, so the shadow bus is frozen: one multi-bit sample is safe.
            if (w_state_nxt == ST_CAPTURE) r_stat_data <= hs.stat_data_in;
            if (w_tmo)           r_timeout_err <= 1'b1;
            else if (hs.err_clr) r_timeout_err <= 1'b0;
        end
    end

    assign hs.write_en    = r_write_en;
    assign hs.stat_valid  = r_stat_valid;
    assign hs.busy        = r_busy;
    assign hs.timeout_err = r_timeout_err;
    assign hs.stat_data   = r_stat_data;
endmodule

// File: tb/tb_cfg_dprio_shadow_status_initiator.sv
// Bench: shadow register loopback on a slower clock, phase model plus directed scenarios.
module tb_cfg_dprio_shadow_status_initiator;
    localparam int DW  = 16;
    localparam int SS  = 2;
    localparam int TMO = 15;

    localparam int PH_IDLE    = 0;
    localparam int PH_DRAIN   = 1;
    localparam int PH_ASSERT  = 2;
    localparam int PH_RELEASE = 3;
    localparam int PH_CAPTURE = 4;

    logic clk  = 1'b0;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #2 clk  = ~clk;
    always #5 sclk = ~sclk;

    cfg_dprio_shadow_status_initiator_if #(.DATA_WIDTH(DW)) hs ();

    cfg_dprio_shadow_status_initiator #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs)
    );

    // Shadow side: updates only while its synchronized write_en is high.
    logic          sh_sy1 = 1'b0, sh_sy2 = 1'b0, sh_ack = 1'b0;
    logic [DW-1:0] sh_q = '0;
    logic [DW-1:0] user_stat = '0;
    logic          ack_mode = 1'b1;
    logic          ack_ovr  = 1'b0;

    always @(posedge sclk) begin
        sh_sy1 <= hs.write_en;
        sh_sy2 <= sh_sy1;
        if (sh_sy2) sh_q <= user_stat;
        sh_ack <= sh_sy2;
    end
    assign hs.write_en_ack = ack_mode ? sh_ack : ack_ovr;
    assign hs.stat_data_in = sh_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the handshake, time spent in it, sticky error, last capture.
    int            ph = PH_IDLE;
    int            dwell = 0;
    bit            ack_hist[$];
    logic [DW-1:0] m_data = '0;
    logic          m_err = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            n_valid = 0;

    always @(posedge clk) begin : model
        logic          p_rst, p_req, p_clr, p_ack;
        logic [DW-1:0] p_din;
        bit            a_s, tmo;
        int            nx;
        p_rst = rst; p_req = hs.req; p_clr = hs.err_clr;
        p_ack = hs.write_en_ack; p_din = hs.stat_data_in;
        if (p_rst) begin
            ph = PH_IDLE; dwell = 0; ack_hist.delete(); m_data = '0; m_err = 1'b0;
        end else begin
            a_s = (ack_hist.size() >= SS) ? ack_hist[ack_hist.size() - SS] : 1'b0;
            ack_hist.push_back(p_ack);
            if (ack_hist.size() > SS) void'(ack_hist.pop_front());
            nx  = ph;
            tmo = 1'b0;
            case (ph)
                PH_IDLE:    if (p_req) nx = a_s ? PH_DRAIN : PH_ASSERT;
                PH_DRAIN:   if (!a_s) nx = PH_ASSERT;
                PH_ASSERT:  if (a_s)  nx = PH_RELEASE;
                PH_RELEASE: if (!a_s) nx = PH_CAPTURE;
                default:    nx = PH_IDLE;
            endcase
            if (nx == ph && ph inside {PH_DRAIN, PH_ASSERT, PH_RELEASE} && dwell + 1 >= TMO) begin
                tmo = 1'b1;
                nx  = PH_IDLE;
            end
            dwell = (nx == ph) ? dwell + 1 : 0;
            if (nx == PH_CAPTURE) m_data = p_din;
            if (tmo)        m_err = 1'b1;
            else if (p_clr) m_err = 1'b0;
            ph = nx;
        end
        #1;
        chk("m_write_en",    hs.write_en,    32'(ph == PH_ASSERT));
        chk("m_stat_valid",  hs.stat_valid,  32'(ph == PH_CAPTURE));
        chk("m_busy",        hs.busy,        32'(ph != PH_IDLE));
        chk("m_stat_data",   hs.stat_data,   32'(m_data));
        chk("m_timeout_err", hs.timeout_err, 32'(m_err));
        if (hs.stat_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected_valid: got stat_valid with data %0h, expected none", hs.stat_data);
            end else begin
                chk("sb_stat_data", hs.stat_data, 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic peek(input int sel);
        case (sel)
            0:       return hs.write_en;
            1:       return hs.busy;
            2:       return hs.stat_valid;
            default: return sh_sy2;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input string nm, input int sel, input logic val, input int budget);
        int k = 0;
        while (k < budget && peek(sel) !== val) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (peek(sel) !== val) begin
            bad++;
            $display("FAIL %s: still %0b after %0d cycles, expected %0b", nm, peek(sel), budget, val);
        end
    endtask

    task automatic pulse_req();
        hs.req = 1'b1;
        @(negedge clk);
        hs.req = 1'b0;
    endtask

    int nv0;
    int we_cnt;

    initial begin
        hs.req = 1'b0;
        hs.err_clr = 1'b0;
        rst = 1'b1;
        cyc(4);
        chk("rst_write_en",    hs.write_en,    0);
        chk("rst_busy",        hs.busy,        0);
        chk("rst_stat_valid",  hs.stat_valid,  0);
        chk("rst_stat_data",   hs.stat_data,   0);
        chk("rst_timeout_err", hs.timeout_err, 0);
        rst = 1'b0;
        cyc(3);

        // Basic loopback snapshot
        user_stat = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        nv0 = n_valid;
        pulse_req();
        chk("t1_we_next_cycle", hs.write_en, 1);
        wait_for("t1_done", 1, 1'b0, 80);
        chk("t1_one_valid", n_valid - nv0, 1);
        chk("t1_stat_data", hs.stat_data, 16'hA5C3);
        chk("t1_busy_low",  hs.busy, 0);

        // Status moves while write_en is high; capture must see the final value
        user_stat = 16'h1234;
        exp_q.push_back(16'h5678);
        pulse_req();
        wait_for("t2_shadow_sync", 3, 1'b1, 40);
        @(posedge sclk);
        #1;
        chk("t2_shadow_first", sh_q, 16'h1234);
        user_stat = 16'h5678;
        @(negedge clk);
        wait_for("t2_done", 1, 1'b0, 80);
        chk("t2_stat_data", hs.stat_data, 16'h5678);

        // Dead user clock: timeout after TMO cycles in ASSERT
        cyc(10);
        user_stat = 16'h0BAD;
        ack_mode  = 1'b0;
        ack_ovr   = 1'b0;
        nv0 = n_valid;
        pulse_req();
        we_cnt = 0;
        while (hs.write_en === 1'b1 && we_cnt < 40) begin
            we_cnt++;
            @(negedge clk);
        end
        chk("t3_we_cycles",   we_cnt, 15);
        chk("t3_timeout_err", hs.timeout_err, 1);
        chk("t3_busy_low",    hs.busy, 0);
        chk("t3_no_valid",    n_valid - nv0, 0);
        chk("t3_data_kept",   hs.stat_data, 16'h5678);

        // Late ack present at the next request: drain first, then complete
        cyc(10);
        ack_ovr = 1'b1;
        cyc(4);
        exp_q.push_back(16'h0BAD);
        nv0 = n_valid;
        pulse_req();
        chk("t4_drain_busy", hs.busy, 1);
        chk("t4_drain_we",   hs.write_en, 0);
        cyc(4);
        chk("t4_drain_hold_we", hs.write_en, 0);
        ack_mode = 1'b1;
        wait_for("t4_we_rise", 0, 1'b1, 20);
        wait_for("t4_done", 1, 1'b0, 80);
        chk("t4_one_valid", n_valid - nv0, 1);
        chk("t4_stat_data", hs.stat_data, 16'h0BAD);
        chk("t4_err_sticky", hs.timeout_err, 1);

        // Extra req pulses while busy are dropped
        user_stat = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        nv0 = n_valid;
        pulse_req();
        cyc(3);
        pulse_req();
        cyc(3);
        pulse_req();
        wait_for("t5_done", 1, 1'b0, 80);
        cyc(6);
        chk("t5_one_valid", n_valid - nv0, 1);
        chk("t5_idle", hs.busy, 0);

        // req held high: back-to-back snapshots 1, 2, 3
        user_stat = 16'h0001;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        nv0 = n_valid;
        hs.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_for("t6_valid", 2, 1'b1, 80);
            if (i < 2) begin
                user_stat = 16'(i + 2);
                cyc(1);
                chk("t6_idle_gap", hs.busy, 0);
                cyc(1);
                chk("t6_retrigger", hs.write_en, 1);
            end else begin
                hs.req = 1'b0;
                cyc(1);
            end
        end
        wait_for("t6_done", 1, 1'b0, 20);
        cyc(6);
        chk("t6_three_valid", n_valid - nv0, 3);
        chk("t6_last_data", hs.stat_data, 16'h0003);

        // Reset in RELEASE (timeout_err still set from earlier)
        user_stat = 16'h7777;
        nv0 = n_valid;
        pulse_req();
        wait_for("t7_we_high", 0, 1'b1, 10);
        wait_for("t7_we_low", 0, 1'b0, 40);
        cyc(1);
        chk("t7_pre_err", hs.timeout_err, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t7_write_en",   hs.write_en, 0);
        chk("t7_busy",       hs.busy, 0);
        chk("t7_stat_data",  hs.stat_data, 0);
        chk("t7_timeout_err", hs.timeout_err, 0);
        cyc(20);
        chk("t7_no_valid", n_valid - nv0, 0);

        // err_clr alone clears next cycle; err_clr with a new timeout loses
        ack_mode = 1'b0;
        ack_ovr  = 1'b0;
        cyc(4);
        pulse_req();
        wait_for("t8_tmo1", 1, 1'b0, 40);
        chk("t8_err_set", hs.timeout_err, 1);
        cyc(2);
        hs.err_clr = 1'b1;
        chk("t8_err_before_clr", hs.timeout_err, 1);
        cyc(1);
        chk("t8_err_cleared", hs.timeout_err, 0);
        pulse_req();
        we_cnt = 0;
        while (hs.write_en === 1'b1 && we_cnt < 40) begin
            we_cnt++;
            @(negedge clk);
        end
        chk("t8_we_cycles_clr_held", we_cnt, 15);
        chk("t8_tmo_beats_clr", hs.timeout_err, 1);
        cyc(1);
        chk("t8_clr_after_tmo", hs.timeout_err, 0);
        hs.err_clr = 1'b0;
        ack_mode = 1'b1;
        cyc(5);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
